// File: rtl/riscv_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for riscv_boot_loader.
// master = stream source / memory side, slave = the loader itself.
interface riscv_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        i_byte;
  logic              i_valid;
  logic              o_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_core_run;
  logic              o_busy;
  logic              o_err;

  modport master (
    output i_byte,
    output i_valid,
    input  o_ready,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_core_run,
    input  o_busy,
    input  o_err
  );

  modport slave (
    input  i_byte,
    input  i_valid,
    output o_ready,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    output o_core_run,
    output o_busy,
    output o_err
  );
endinterface

// File: rtl/riscv_boot_loader.sv
// Length-prefixed byte-stream loader into instruction memory; stalls core.
// Define RISCV_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module riscv_boot_loader #(
  parameter int ADDR_W = 8
) (
  input logic                clk,
  input logic                a_rst,
  riscv_boot_loader_if.slave bus
);

`ifdef RISCV_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE,
    S_DONE, S_ERROR, S_CHECK
  } state_t;
  localparam state_t S_FINAL = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE,
    S_DONE, S_ERROR
  } state_t;
  localparam state_t S_FINAL = S_DONE;
`endif

  // Largest image that fits: 2^ADDR_W words.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t      state;
  state_t      state_n;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [15:0] n_full;
  logic [31:0] word;
  logic [1:0]  bidx;
  logic        accept;
  logic        xfer;
`ifdef RISCV_BOOT_CHECKSUM_EN
  logic [7:0]  csum;
`endif

`ifdef RISCV_BOOT_CHECKSUM_EN
  assign accept = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                  (state == S_DATA)   || (state == S_CHECK);
`else
  assign accept = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                  (state == S_DATA);
`endif

  assign xfer    = bus.i_valid && accept;
  assign n_full  = {bus.i_byte, len[7:0]};
  assign cnt_inc = cnt + 16'd1;

  // State register.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= S_LEN_LO;
    else       state <= state_n;
  end

  // Next-state decode; DONE and ERROR only leave through reset.
  always_comb begin
    state_n = state;
    unique case (state)
      S_LEN_LO: if (xfer) state_n = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if ({1'b0, n_full} > CAP) state_n = S_ERROR;
          else if (n_full == 16'd0) state_n = S_FINAL;
          else                      state_n = S_DATA;
        end
      end
      S_DATA: if (xfer && bidx == 2'd3) state_n = S_WRITE;
      S_WRITE: begin
        if (cnt_inc == len) state_n = S_FINAL;
        else                state_n = S_DATA;
      end
`ifdef RISCV_BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          if (bus.i_byte == csum) state_n = S_DONE;
          else                    state_n = S_ERROR;
        end
      end
`endif
      default: state_n = state;
    endcase
  end

  // Length capture, word assembly and word counter.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      len  <= '0;
      cnt  <= '0;
      word <= '0;
      bidx <= '0;
    end else begin
      if (xfer && state == S_LEN_LO) len[7:0]  <= bus.i_byte;
      if (xfer && state == S_LEN_HI) len[15:8] <= bus.i_byte;
      if (xfer && state == S_DATA) begin
        word[{bidx, 3'b000} +: 8] <= bus.i_byte;
        bidx <= bidx + 2'd1;
      end
      if (state == S_WRITE) cnt <= cnt_inc;
    end
  end

`ifdef RISCV_BOOT_CHECKSUM_EN
  // Running XOR of every byte before the checksum byte.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)                          csum <= '0;
    else if (xfer && state != S_CHECK) csum <= csum ^ bus.i_byte;
  end
`endif

  // Ready is masked during reset so the source never sees a false accept.
  assign bus.o_ready    = accept && !a_rst;
  assign bus.o_wr_en    = (state == S_WRITE);
  assign bus.o_wr_addr  = cnt[ADDR_W-1:0];
  assign bus.o_wr_data  = word;
  assign bus.o_core_run = (state == S_DONE);
  assign bus.o_err      = (state == S_ERROR);
`ifdef RISCV_BOOT_CHECKSUM_EN
  assign bus.o_busy = (state == S_LEN_HI) || (state == S_DATA) ||
                      (state == S_WRITE)  || (state == S_CHECK);
`else
  assign bus.o_busy = (state == S_LEN_HI) || (state == S_DATA) ||
                      (state == S_WRITE);
`endif

endmodule

// File: doc/riscv_boot_loader.md
# riscv_boot_loader

Byte-stream program loader that sits directly upstream of the single-cycle RISC-V core's instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into instruction memory at consecutive word addresses from 0. It holds the core stalled until the image is complete, then releases it.

## Interface
Parameters:
- ADDR_W, default 8: instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  input  1  single clock; all state on rising edge.
- a_rst  input  1  asynchronous, active-high reset.
- i_byte  input  8  stream byte.
- i_valid  input  1  i_byte valid.
- o_ready  output  1  loader can accept a byte this cycle.
- o_wr_en  output  1  instruction-memory write strobe, one cycle per word.
- o_wr_addr  output  ADDR_W  word address; byte address = o_wr_addr<<2.
- o_wr_data  output  32  assembled instruction word.
- o_core_run  output  1  high once the image is loaded; core PC update is gated by it.
- o_busy  output  1  high while a load is in progress (LEN_HI, DATA, WRITE, CHECK).
- o_err  output  1  sticky error flag.

## Operation
- A byte transfers on a rising edge when i_valid && o_ready. i_byte is ignored otherwise.
- Stream format: N[7:0], N[15:8], then N words of 4 bytes each, LSB first.
- States:
  - LEN_LO: capture N low byte, then go to LEN_HI.
  - LEN_HI: capture the high byte. Then:
    - N > 2^ADDR_W: go to ERROR.
    - N == 0: go to DONE, or CHECK when the checksum is enabled.
    - Otherwise: go to DATA.
  - DATA: shift bytes into the word register at byte index 0..3. When the 4th byte transfers, go to WRITE.
  - WRITE: o_wr_en=1 for exactly one cycle, with o_wr_addr = word counter and o_wr_data = assembled word. Then increment the counter. If counter+1 == N, go to DONE (or CHECK); otherwise go to DATA.
  - DONE: terminal; o_core_run=1.
  - ERROR: terminal; o_err=1; o_core_run stays 0.
- o_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK. It is 0 in WRITE, DONE and ERROR.
- The word counter is 16 bits. o_wr_addr is its low ADDR_W bits. The length check guarantees no wrap.
- Bytes presented in DONE or ERROR are never accepted. Leaving either state requires a_rst.
- Instruction-memory contents are never cleared by this block.

## Timing
- Reset values:
  - Outputs: o_ready=0 while a_rst is high, then 1 (LEN_LO) from the first cycle after release. o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_core_run=0, o_busy=0, o_err=0.
  - Internal: state=LEN_LO, counter=0, checksum=0.
- All outputs are decoded from registered state and datapath registers. No output depends combinationally on i_valid or i_byte.
- Latency:
  - The 4th byte of a word transfers on edge k. o_wr_en is high during the cycle after edge k. o_ready is low for that one cycle.
  - o_core_run rises in the cycle after the final WRITE cycle, or after the LEN_HI/CHECK transfer for N==0.
- Throughput: 5 cycles per word minimum (4 byte cycles plus 1 write cycle). Gaps in i_valid stretch DATA without loss.
- i_valid held high during WRITE must not duplicate or drop the byte. The byte transfers on the first DATA cycle.
- a_rst asserted mid-load aborts immediately. Words already written stay written; the next load restarts at address 0.

## Configuration
- RISCV_BOOT_CHECKSUM_EN defined:
  - After the last word (or after LEN_HI when N==0), the CHECK state accepts one byte.
  - Byte equal to the XOR of all preceding stream bytes, length bytes included: go to DONE.
  - Otherwise: go to ERROR.
- RISCV_BOOT_CHECKSUM_EN undefined:
  - The CHECK state and checksum register do not exist.
  - The final WRITE goes directly to DONE.

## Test plan
- Reset: hold a_rst for 3 cycles, then release. Required: all outputs 0 during reset; o_ready=1 one cycle after release.
- Two-word load: stream 02 00 93 00 50 00 13 01 A0 00 (plus checksum 73 if enabled). Required:
  - Write at addr 0 with data 0x00500093, then at addr 1 with 0x00A00113.
  - Exactly 2 o_wr_en pulses.
  - o_core_run=1 after the last write; o_err=0.
- Empty image: stream 00 00 (plus 00 if checksum enabled). Required: no o_wr_en; o_core_run=1; further bytes get o_ready=0.
- Oversize, ADDR_W=8: stream 01 01 (N=257). Required: ERROR; o_err=1; o_core_run=0; no writes.
- Backpressure: two-word load with i_valid toggled randomly and held high through WRITE cycles. Required: identical addr/data as the two-word load; o_ready low only in WRITE.
- Checksum (macro on): two-word load with a final byte of 72 instead of 73. Required: both writes occur; then o_err=1 and o_core_run stays 0. Mid-load a_rst followed by a correct stream must reload cleanly.
